data_bus_demux2: RTL and testbench

- One-to-two data-bus router: the inverse of the 2:1 select path. Takes the core's single data-memory request channel and steers each request to device 0 (RAM) or device 1 (MMIO) by address decode.
- Tracks outstanding reads and routes read responses back to the core in issue order through a registered response stage.
- Sits between the rvsimple core's data port and the RAM/MMIO slaves.

---
 rtl/rvsimple_bus_pkg.sv | 17 +
 rtl/bus_outstanding_tracker.sv | 79 +++++++
 rtl/data_bus_demux2.sv | 97 +++++++++
 tb/tb_data_bus_demux2.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvsimple_bus_pkg.sv
// Shared memory-map and target constants for the rvsimple data bus.
// Core, router and testbench all import this so they agree on the map.
package rvsimple_bus_pkg;

    typedef logic bus_tgt_t;

    localparam bus_tgt_t TGT_RAM  = 1'b0;
    localparam bus_tgt_t TGT_MMIO = 1'b1;

    localparam int unsigned BUS_ADDR_W = 32;

    localparam logic [BUS_ADDR_W-1:0] DEV1_BASE_DEFAULT = 32'h8000_0000;
    localparam logic [BUS_ADDR_W-1:0] DEV1_MASK_DEFAULT = 32'hF000_0000;

    localparam int unsigned MAX_OUT_DEFAULT = 4;

endpackage

// File: rtl/bus_outstanding_tracker.sv
// Outstanding-read bookkeeping for the data-bus router: counts reads in flight,
// remembers which device owns them, gates new requests and flags stray responses.
module bus_outstanding_tracker
    import rvsimple_bus_pkg::*;
#(
    parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT,
    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic             req_write,
    input  bus_tgt_t         tgt,
    input  logic             tgt_ready,
    input  logic             dev0_rvalid,
    input  logic             dev1_rvalid,
    output logic             allow_c,
    output logic             resp_hit_c,
    output bus_tgt_t         cur_tgt,
    output logic [CNT_W-1:0] out_cnt,
    output logic             err_stray
);

    logic idle_c;
    logic same_c;
    logic room_c;
    logic fire_c;
    logic rd_fire_c;
    logic sel_rvalid_c;
    logic stray_c;

    // Only one device may own in-flight reads, which keeps responses in issue order.
    always_comb begin
        idle_c       = 1'b0;
        same_c       = 1'b0;
        room_c       = 1'b0;
        allow_c      = 1'b0;
        fire_c       = 1'b0;
        rd_fire_c    = 1'b0;
        sel_rvalid_c = 1'b0;
        resp_hit_c   = 1'b0;
        stray_c      = 1'b0;

        idle_c  = (out_cnt == '0);
        same_c  = (tgt == cur_tgt);
        room_c  = (out_cnt < CNT_W'(MAX_OUT));
        allow_c = req_write ? (idle_c | same_c) : (idle_c | (same_c & room_c));

        fire_c    = req_valid & allow_c & tgt_ready;
        rd_fire_c = fire_c & ~req_write;

        sel_rvalid_c = (cur_tgt == TGT_MMIO) ? dev1_rvalid : dev0_rvalid;
        resp_hit_c   = sel_rvalid_c & ~idle_c;
        stray_c      = (dev0_rvalid & ((cur_tgt != TGT_RAM)  | idle_c))
                     | (dev1_rvalid & ((cur_tgt != TGT_MMIO) | idle_c));
    end

    // A response only retires previously issued reads, so issue+hit leaves the count alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt   <= '0;
            cur_tgt   <= TGT_RAM;
            err_stray <= 1'b0;
        end else begin
            if (fire_c) begin
                cur_tgt <= tgt;
            end
            if (rd_fire_c && !resp_hit_c) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end else if (resp_hit_c && !rd_fire_c) begin
                out_cnt <= out_cnt - CNT_W'(1);
            end
            if (stray_c) begin
                err_stray <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_bus_demux2.sv
// One-to-two data-bus router: steers core requests to RAM or MMIO by address
// decode and returns read data in issue order through a registered stage.
module data_bus_demux2
    import rvsimple_bus_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] DEV1_BASE  = ADDR_WIDTH'(DEV1_BASE_DEFAULT),
    parameter logic [ADDR_WIDTH-1:0] DEV1_MASK  = ADDR_WIDTH'(DEV1_MASK_DEFAULT),
    parameter int unsigned           MAX_OUT    = MAX_OUT_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    dev0_valid,
    output logic                    dev1_valid,
    input  logic                    dev0_ready,
    input  logic                    dev1_ready,
    output logic [ADDR_WIDTH-1:0]   dev_addr,
    output logic [DATA_WIDTH-1:0]   dev_wdata,
    output logic [DATA_WIDTH/8-1:0] dev_be,
    output logic                    dev_write,
    input  logic                    dev0_rvalid,
    input  logic                    dev1_rvalid,
    input  logic [DATA_WIDTH-1:0]   dev0_rdata,
    input  logic [DATA_WIDTH-1:0]   dev1_rdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    err_stray
);

    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    bus_tgt_t         tgt_c;
    bus_tgt_t         cur_tgt;
    logic             allow_c;
    logic             resp_hit_c;
    logic             tgt_ready_c;
    logic [CNT_W-1:0] out_cnt;

    // Decode and steering; valid is deliberately independent of the device's ready.
    always_comb begin
        tgt_c       = TGT_RAM;
        tgt_ready_c = 1'b0;
        dev0_valid  = 1'b0;
        dev1_valid  = 1'b0;
        req_ready   = 1'b0;

        tgt_c       = bus_tgt_t'((req_addr & DEV1_MASK) == DEV1_BASE);
        tgt_ready_c = (tgt_c == TGT_MMIO) ? dev1_ready : dev0_ready;
        dev0_valid  = req_valid & allow_c & (tgt_c == TGT_RAM);
        dev1_valid  = req_valid & allow_c & (tgt_c == TGT_MMIO);
        req_ready   = allow_c & tgt_ready_c;
    end

    assign dev_addr  = req_addr;
    assign dev_wdata = req_wdata;
    assign dev_be    = req_be;
    assign dev_write = req_write;

    bus_outstanding_tracker #(
        .MAX_OUT (MAX_OUT)
    ) u_trk (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .tgt         (tgt_c),
        .tgt_ready   (tgt_ready_c),
        .dev0_rvalid (dev0_rvalid),
        .dev1_rvalid (dev1_rvalid),
        .allow_c     (allow_c),
        .resp_hit_c  (resp_hit_c),
        .cur_tgt     (cur_tgt),
        .out_cnt     (out_cnt),
        .err_stray   (err_stray)
    );

    // Response stage: data holds its last value when no expected response arrives.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= resp_hit_c;
            if (resp_hit_c) begin
                resp_rdata <= (cur_tgt == TGT_MMIO) ? dev1_rdata : dev0_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_demux2.sv
// Self-checking bench for data_bus_demux2: directed scenarios plus a randomized
// run against a queue-based reference model of the routing rules.
module tb_data_bus_demux2;
    import rvsimple_bus_pkg::*;

    localparam int unsigned MAX_OUT = 4;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        dev0_valid;
    logic        dev1_valid;
    logic        dev0_ready;
    logic        dev1_ready;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_be;
    logic        dev_write;
    logic        dev0_rvalid;
    logic        dev1_rvalid;
    logic [31:0] dev0_rdata;
    logic [31:0] dev1_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err_stray;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of in-flight read targets plus last issued target.
    bit          pend_tgt[$];
    bit          m_tgt;
    bit          m_err;
    bit          m_rv;
    logic [31:0] m_rd;

    data_bus_demux2 dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_write   (req_write),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .dev0_valid  (dev0_valid),
        .dev1_valid  (dev1_valid),
        .dev0_ready  (dev0_ready),
        .dev1_ready  (dev1_ready),
        .dev_addr    (dev_addr),
        .dev_wdata   (dev_wdata),
        .dev_be      (dev_be),
        .dev_write   (dev_write),
        .dev0_rvalid (dev0_rvalid),
        .dev1_rvalid (dev1_rvalid),
        .dev0_rdata  (dev0_rdata),
        .dev1_rdata  (dev1_rdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .err_stray   (err_stray)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit m_decode(input logic [31:0] a);
        return (a & DEV1_MASK_DEFAULT) == DEV1_BASE_DEFAULT;
    endfunction

    function automatic bit m_allow();
        bit t;
        t = m_decode(req_addr);
        if (pend_tgt.size() == 0) return 1'b1;
        if (t != m_tgt) return 1'b0;
        if (req_write) return 1'b1;
        return pend_tgt.size() < MAX_OUT;
    endfunction

    task automatic model_reset();
        pend_tgt.delete();
        m_tgt = 1'b0;
        m_err = 1'b0;
        m_rv  = 1'b0;
        m_rd  = 32'h0;
    endtask

    task automatic model_edge();
        bit t;
        bit fire;
        bit hit;
        bit stray;
        int n;
        n     = pend_tgt.size();
        t     = m_decode(req_addr);
        fire  = req_valid && m_allow() && (t ? dev1_ready : dev0_ready);
        hit   = (m_tgt ? dev1_rvalid : dev0_rvalid) && (n > 0);
        stray = (dev0_rvalid && (m_tgt || n == 0)) || (dev1_rvalid && (!m_tgt || n == 0));
        m_rv  = hit;
        if (hit) begin
            m_rd = m_tgt ? dev1_rdata : dev0_rdata;
            void'(pend_tgt.pop_front());
        end
        if (stray) m_err = 1'b1;
        if (fire) begin
            m_tgt = t;
            if (!req_write) pend_tgt.push_back(t);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        req_write   = 1'b0;
        req_wdata   = 32'h0;
        req_be      = 4'hF;
        dev0_ready  = 1'b0;
        dev1_ready  = 1'b0;
        dev0_rvalid = 1'b0;
        dev1_rvalid = 1'b0;
        dev0_rdata  = 32'h0;
        dev1_rdata  = 32'h0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        checks++; if (err_stray !== 1'b0) begin errors++; $display("FAIL reset_err_stray got %b want 0", err_stray); end
        checks++; if (dut.u_trk.out_cnt !== 3'd0) begin errors++; $display("FAIL reset_out_cnt got %0d want 0", dut.u_trk.out_cnt); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        drive_idle();
        req_valid = 1'b1; req_addr = 32'h0000_0010; dev0_ready = 1'b1;
        #1;
        checks++; if (dev0_valid !== 1'b1) begin errors++; $display("FAIL single_dev0_valid got %b want 1", dev0_valid); end
        checks++; if (dev1_valid !== 1'b0) begin errors++; $display("FAIL single_dev1_valid got %b want 0", dev1_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_req_ready got %b want 1", req_ready); end
        tick();
        drive_idle();
        dev0_rvalid = 1'b1; dev0_rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (dut.u_trk.out_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt_pending got %0d want 1", dut.u_trk.out_cnt); end
        tick();
        drive_idle();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_resp_rdata got %h want deadbeef", resp_rdata); end
        checks++; if (dut.u_trk.out_cnt !== 3'd0) begin errors++; $display("FAIL single_cnt_done got %0d want 0", dut.u_trk.out_cnt); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_resp_drop got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata_hold got %h want deadbeef", resp_rdata); end
    endtask

    task automatic test_switch_stall();
        drive_idle();
        req_valid = 1'b1; req_addr = 32'h0000_0000; dev0_ready = 1'b1;
        tick();
        drive_idle();
        req_valid = 1'b1; req_addr = 32'h8000_0004; dev1_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready cyc %0d got %b want 0", i, req_ready); end
            checks++; if (dev1_valid !== 1'b0) begin errors++; $display("FAIL stall_dev1_valid cyc %0d got %b want 0", i, dev1_valid); end
            tick();
        end
        dev0_rvalid = 1'b1; dev0_rdata = 32'h0BAD_0001;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_resp_cycle got %b want 0", req_ready); end
        tick();
        dev0_rvalid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL switch_req_ready got %b want 1", req_ready); end
        checks++; if (dev1_valid !== 1'b1) begin errors++; $display("FAIL switch_dev1_valid got %b want 1", dev1_valid); end
        checks++; if (resp_rdata !== 32'h0BAD_0001) begin errors++; $display("FAIL switch_prev_rdata got %h want 0bad0001", resp_rdata); end
        tick();
        drive_idle();
        dev1_rvalid = 1'b1; dev1_rdata = 32'h1234_5678;
        tick();
        drive_idle();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL switch_dev1_resp got %b/%h want 1/12345678", resp_valid, resp_rdata); end
        tick();
    endtask

    task automatic test_full();
        drive_idle();
        req_valid = 1'b1; dev0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h0000_0100 + 32'(4 * i);
            tick();
        end
        req_addr = 32'h0000_0110;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_req_ready got %b want 0", req_ready); end
        checks++; if (dev0_valid !== 1'b0) begin errors++; $display("FAIL full_dev0_valid got %b want 0", dev0_valid); end
        checks++; if (dut.u_trk.out_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got %0d want 4", dut.u_trk.out_cnt); end
        dev0_rvalid = 1'b1; dev0_rdata = 32'h1111_0000;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_resp_cycle got %b want 0", req_ready); end
        tick();
        dev0_rvalid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL full_fifth_ready got %b want 1", req_ready); end
        tick();
        checks++; if (dut.u_trk.out_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt_refill got %0d want 4", dut.u_trk.out_cnt); end
        req_write = 1'b1; req_addr = 32'h8000_0000; dev1_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0 || dev1_valid !== 1'b0) begin errors++; $display("FAIL full_other_write got %b/%b want 0/0", req_ready, dev1_valid); end
        req_addr = 32'h0000_0200;
        #1;
        checks++; if (req_ready !== 1'b1 || dev0_valid !== 1'b1) begin errors++; $display("FAIL full_same_write got %b/%b want 1/1", req_ready, dev0_valid); end
        tick();
        drive_idle();
        checks++; if (dut.u_trk.out_cnt !== 3'd4) begin errors++; $display("FAIL full_write_cnt got %0d want 4", dut.u_trk.out_cnt); end
        for (int i = 0; i < 4; i++) begin
            dev0_rvalid = 1'b1; dev0_rdata = 32'hA000_0000 + 32'(i);
            tick();
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL full_drain %0d got %b/%h want 1/%h", i, resp_valid, resp_rdata, 32'hA000_0000 + 32'(i)); end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_simultaneous();
        drive_idle();
        req_valid = 1'b1; dev0_ready = 1'b1;
        req_addr = 32'h0000_0020; tick();
        req_addr = 32'h0000_0024; tick();
        req_addr = 32'h0000_0028; dev0_rvalid = 1'b1; dev0_rdata = 32'h5A5A_5A5A;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL simul_req_ready got %b want 1", req_ready); end
        tick();
        drive_idle();
        checks++; if (dut.u_trk.out_cnt !== 3'd2) begin errors++; $display("FAIL simul_cnt got %0d want 2", dut.u_trk.out_cnt); end
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL simul_resp got %b/%h want 1/5a5a5a5a", resp_valid, resp_rdata); end
        repeat (2) begin
            dev0_rvalid = 1'b1; dev0_rdata = 32'h0000_0C0C;
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_stray_write();
        drive_idle();
        dev1_rvalid = 1'b1; dev1_rdata = 32'h7777_7777;
        tick();
        drive_idle();
        checks++; if (err_stray !== 1'b1) begin errors++; $display("FAIL stray_set got %b want 1", err_stray); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stray_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata === 32'h7777_7777) begin errors++; $display("FAIL stray_rdata got %h want not 77777777", resp_rdata); end
        tick();
        checks++; if (err_stray !== 1'b1) begin errors++; $display("FAIL stray_sticky got %b want 1", err_stray); end
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'hCAFE_F00D; dev1_ready = 1'b1;
        #1;
        checks++; if (dev1_valid !== 1'b1 || dev0_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL write_steer got %b%b%b want 101", dev1_valid, dev0_valid, req_ready); end
        checks++; if (dev_wdata !== 32'hCAFE_F00D || dev_write !== 1'b1) begin errors++; $display("FAIL write_bcast got %h/%b want cafef00d/1", dev_wdata, dev_write); end
        tick();
        drive_idle();
        checks++; if (dut.u_trk.out_cnt !== 3'd0 || resp_valid !== 1'b0) begin errors++; $display("FAIL write_posted got %0d/%b want 0/0", dut.u_trk.out_cnt, resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL write_no_resp got %b want 0", resp_valid); end
    endtask

    task automatic test_async_reset();
        drive_idle();
        req_valid = 1'b1; dev0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h0000_0300 + 32'(4 * i);
            tick();
        end
        drive_idle();
        dev0_rvalid = 1'b1; dev0_rdata = 32'h3333_3333;
        tick();
        drive_idle();
        checks++; if (dut.u_trk.out_cnt !== 3'd3 || resp_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got %0d/%b want 3/1", dut.u_trk.out_cnt, resp_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (dut.u_trk.out_cnt !== 3'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", dut.u_trk.out_cnt); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL arst_resp_valid got %b want 0", resp_valid); end
        checks++; if (err_stray !== 1'b0) begin errors++; $display("FAIL arst_err got %b want 0", err_stray); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL arst_rdata got %h want 0", resp_rdata); end
        model_reset();
        #2 reset_n = 1'b1;
        req_valid = 1'b1; req_addr = 32'h8000_0000; dev1_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || dev1_valid !== 1'b1) begin errors++; $display("FAIL arst_dev1_accept got %b/%b want 1/1", req_ready, dev1_valid); end
        tick();
        drive_idle();
        checks++; if (dut.u_trk.out_cnt !== 3'd1) begin errors++; $display("FAIL arst_cnt_after got %0d want 1", dut.u_trk.out_cnt); end
        dev1_rvalid = 1'b1; dev1_rdata = 32'h4444_4444;
        tick();
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        bit t;
        bit a;
        int bad = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            drive_idle();
            req_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       req_addr = {16'h0000, 16'($urandom)};
                1:       req_addr = {16'h8000, 16'($urandom)};
                default: req_addr = {16'h9000, 16'($urandom)};
            endcase
            req_write  = ($urandom_range(0, 3) == 0);
            req_wdata  = $urandom;
            req_be     = 4'($urandom);
            dev0_ready = ($urandom_range(0, 3) != 0);
            dev1_ready = ($urandom_range(0, 3) != 0);
            dev0_rdata = $urandom;
            dev1_rdata = $urandom;
            if (pend_tgt.size() > 0 && $urandom_range(0, 1) == 1) begin
                if (pend_tgt[0]) dev1_rvalid = 1'b1; else dev0_rvalid = 1'b1;
            end
            if ($urandom_range(0, 63) == 0) begin
                if (m_tgt) dev0_rvalid = 1'b1; else dev1_rvalid = 1'b1;
            end
            #1;
            t = m_decode(req_addr);
            a = m_allow();
            checks++; if (dev0_valid !== (req_valid && a && !t)) begin errors++; bad++; $display("FAIL rand_dev0_valid cyc %0d got %b want %b", cyc, dev0_valid, req_valid && a && !t); end
            checks++; if (dev1_valid !== (req_valid && a && t)) begin errors++; bad++; $display("FAIL rand_dev1_valid cyc %0d got %b want %b", cyc, dev1_valid, req_valid && a && t); end
            checks++; if (req_ready !== (a && (t ? dev1_ready : dev0_ready))) begin errors++; bad++; $display("FAIL rand_req_ready cyc %0d got %b want %b", cyc, req_ready, a && (t ? dev1_ready : dev0_ready)); end
            checks++; if (dev_addr !== req_addr || dev_be !== req_be || dev_write !== req_write) begin errors++; bad++; $display("FAIL rand_bcast cyc %0d got %h want %h", cyc, dev_addr, req_addr); end
            tick();
            checks++; if (resp_valid !== m_rv) begin errors++; bad++; $display("FAIL rand_resp_valid cyc %0d got %b want %b", cyc, resp_valid, m_rv); end
            checks++; if (resp_rdata !== m_rd) begin errors++; bad++; $display("FAIL rand_resp_rdata cyc %0d got %h want %h", cyc, resp_rdata, m_rd); end
            checks++; if (err_stray !== m_err) begin errors++; bad++; $display("FAIL rand_err_stray cyc %0d got %b want %b", cyc, err_stray, m_err); end
            checks++; if (dut.u_trk.out_cnt !== 3'(pend_tgt.size())) begin errors++; bad++; $display("FAIL rand_out_cnt cyc %0d got %0d want %0d", cyc, dut.u_trk.out_cnt, pend_tgt.size()); end
            if (bad > 20) break;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_switch_stall();
        test_full();
        test_simultaneous();
        test_stray_write();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
